// File: rtl/bp_stream_lite_arbiter.sv
// ---------------------------------------------------------------------------
// bp_stream_lite_arbiter_pkg
//   BedRock memory message header layout and enums used by the arbiter and its
//   clients, fixed to the default processor configuration.
//
// bp_stream_lite_arbiter
//   Round-robin arbiter sharing one BedRock memory stream channel between
//   num_masters_p stream masters and a single downstream consumer. The grant is
//   held for every beat of a message. A master may hold lock on a last beat to
//   keep the grant across messages. Arbitration is zero-latency: the winner's
//   first beat is presented downstream in the cycle it is selected.
//
// Ports
//   clk_i, reset_n_i   clock (rising edge), asynchronous active-low reset
//   mem_header_i       per-master headers, master g at [g*hdr_w +: hdr_w]
//   mem_data_i         per-master beat data
//   mem_v_i            per-master valid
//   mem_lock_i         per-master lock, sampled on a last-beat handshake
//   mem_ready_o        per-master ready (only the selected master can see 1)
//   mem_header_o       selected header
//   mem_data_o         selected data
//   mem_v_o            selected valid
//   mem_lock_o         selected master's lock
//   mem_ready_i        downstream ready
//   grant_id_o         index of the current or selected master
// ---------------------------------------------------------------------------
package bp_stream_lite_arbiter_pkg;

   typedef enum logic [0:0] {
      e_bp_default_cfg = 1'b0
   } bp_params_e;

   localparam int unsigned paddr_width_p  = 40;
   localparam int unsigned lce_id_width_p = 4;
   localparam int unsigned lce_assoc_p    = 8;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   // Encoded as log2 of the message size in bytes.
   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic [$clog2(lce_assoc_p)-1:0] way_id;
      logic [lce_id_width_p-1:0]      lce_id;
      bp_bedrock_msg_size_e           size;
      logic [paddr_width_p-1:0]       addr;
      logic [3:0]                     subop;
      bp_bedrock_mem_type_e           msg_type;
   } bp_bedrock_mem_msg_header_s;

endpackage

module bp_stream_lite_arbiter
   import bp_stream_lite_arbiter_pkg::*;
#(
   parameter bp_params_e  bp_params_p    = e_bp_default_cfg,
   parameter int unsigned num_masters_p  = 2,
   parameter int unsigned data_width_p   = 64,
   parameter int unsigned max_beats_p    = 8,
   parameter int unsigned payload_mask_p = 0,
   localparam int unsigned hdr_w = $bits(bp_bedrock_mem_msg_header_s),
   localparam int unsigned id_w  = $clog2(num_masters_p)
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic [num_masters_p*hdr_w-1:0]         mem_header_i,
   input  logic [num_masters_p*data_width_p-1:0]  mem_data_i,
   input  logic [num_masters_p-1:0]               mem_v_i,
   input  logic [num_masters_p-1:0]               mem_lock_i,
   output logic [num_masters_p-1:0]               mem_ready_o,
   output logic [hdr_w-1:0]                       mem_header_o,
   output logic [data_width_p-1:0]                mem_data_o,
   output logic                                   mem_v_o,
   output logic                                   mem_lock_o,
   input  logic                                   mem_ready_i,
   output logic [id_w-1:0]                        grant_id_o
);

   if (bp_params_p != e_bp_default_cfg) begin : g_chk_cfg
      $error("bp_stream_lite_arbiter: only the default config header layout is supported");
   end
   if (num_masters_p < 2) begin : g_chk_masters
      $error("bp_stream_lite_arbiter: num_masters_p must be at least 2");
   end
   if ((data_width_p % 8) != 0) begin : g_chk_width
      $error("bp_stream_lite_arbiter: data_width_p must be a multiple of 8");
   end

   localparam int unsigned cnt_w     = (max_beats_p > 1) ? $clog2(max_beats_p) : 1;
   localparam int unsigned lg_bpb_lp = $clog2(data_width_p / 8);
   localparam int unsigned lg_max_lp = $clog2(max_beats_p);
   localparam logic [15:0] mask_lp   = 16'(payload_mask_p);

   typedef logic [id_w-1:0]  id_t;
   typedef logic [cnt_w-1:0] cnt_t;
   typedef enum logic [1:0] {e_idle, e_stream, e_lock} state_e;

   state_e state_r;
   id_t    rr_ptr_r;
   id_t    gnt_r;
   cnt_t   cnt_r;

   id_t    sel;
   cnt_t   beats_m1;
   logic   hs;

   bp_bedrock_mem_msg_header_s hdr_a  [num_masters_p];
   logic [data_width_p-1:0]    data_a [num_masters_p];

   for (genvar g = 0; g < num_masters_p; g++) begin : g_unpack
      assign hdr_a[g]  = mem_header_i[g*hdr_w +: hdr_w];
      assign data_a[g] = mem_data_i[g*data_width_p +: data_width_p];
   end

   function automatic id_t next_id(id_t i);
      return (32'(i) == num_masters_p - 1) ? '0 : i + 1'b1;
   endfunction

   // Winner search: the lowest offset from rr_ptr_r wins, so scan offsets
   // from high to low and let the last hit stand. Outside IDLE the grant is
   // pinned to gnt_r.
   always_comb begin
      int idx;
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and infers a latch.
      sel = rr_ptr_r;
      idx = 0;
      if (state_r == e_idle) begin
         for (int k = int'(num_masters_p) - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= int'(num_masters_p)) idx = idx - int'(num_masters_p);
            if (mem_v_i[idx]) sel = id_t'(idx);
         end
      end else begin
         sel = gnt_r;
      end
   end

   // Beats of a message starting now, less one. Only meaningful on a first
   // beat (IDLE or LOCK); STREAM counts with cnt_r and ignores the header.
   always_comb begin
      int unsigned sz;
      int unsigned lgb;
      sz  = 32'(hdr_a[sel].size);
      lgb = 0;
      if (mask_lp[hdr_a[sel].msg_type] && (sz > lg_bpb_lp)) lgb = sz - lg_bpb_lp;
      if (lgb > lg_max_lp) lgb = lg_max_lp;
      beats_m1 = cnt_t'((32'd1 << lgb) - 32'd1);
   end

   // Outputs are forced to zero while reset is asserted, independent of the
   // clock, so a mid-message reset drops the channel immediately.
   always_comb begin
      mem_ready_o = '0;
      if (reset_n_i) mem_ready_o[sel] = mem_ready_i;
   end

   assign mem_v_o      = reset_n_i & mem_v_i[sel];
   assign mem_header_o = reset_n_i ? hdr_a[sel]     : '0;
   assign mem_data_o   = reset_n_i ? data_a[sel]    : '0;
   assign mem_lock_o   = reset_n_i & mem_lock_i[sel];
   assign grant_id_o   = reset_n_i ? sel            : '0;

   assign hs = mem_v_o & mem_ready_i;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r  <= e_idle;
         rr_ptr_r <= '0;
         gnt_r    <= '0;
         cnt_r    <= '0;
      end else if (hs) begin
         unique case (state_r)
            e_idle, e_lock: begin
               // First beat of a message; in LOCK sel is already gnt_r.
               if (beats_m1 != '0) begin
                  gnt_r   <= sel;
                  cnt_r   <= beats_m1;
                  state_r <= e_stream;
               end else if (mem_lock_i[sel]) begin
                  gnt_r   <= sel;
                  state_r <= e_lock;
               end else begin
                  rr_ptr_r <= next_id(sel);
                  state_r  <= e_idle;
               end
            end
            e_stream: begin
               cnt_r <= cnt_r - 1'b1;
               if (cnt_r == cnt_t'(1)) begin
                  if (mem_lock_i[gnt_r]) begin
                     state_r <= e_lock;
                  end else begin
                     rr_ptr_r <= next_id(gnt_r);
                     state_r  <= e_idle;
                  end
               end
            end
            default: state_r <= e_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_stream_lite_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for bp_stream_lite_arbiter with two masters, 64-bit
// beats, up to 8 beats per message, and write / uncached-write as the data
// carrying message types. Inputs change on the falling edge and outputs are
// compared 1 time unit later, before the next rising edge.
// ---------------------------------------------------------------------------
module tb_bp_stream_lite_arbiter;
   import bp_stream_lite_arbiter_pkg::*;

   localparam int unsigned HW = $bits(bp_bedrock_mem_msg_header_s);
   localparam int unsigned PM = (1 << e_bedrock_mem_wr) | (1 << e_bedrock_mem_uc_wr);

   logic                        clk_i = 1'b0;
   logic                        reset_n_i;
   bp_bedrock_mem_msg_header_s  hdr [2];
   logic [63:0]                 dat [2];
   logic [1:0]                  v_in;
   logic [1:0]                  lock_in;
   logic                        ready_in;

   logic [2*HW-1:0]             mem_header_i;
   logic [127:0]                mem_data_i;
   logic [1:0]                  ready_o;
   logic [HW-1:0]               hdr_o;
   logic [63:0]                 data_o;
   logic                        v_o;
   logic                        lock_o;
   logic [0:0]                  gid;

   int n_cmp;
   int n_bad;

   assign mem_header_i = {hdr[1], hdr[0]};
   assign mem_data_i   = {dat[1], dat[0]};

   always #5 clk_i = ~clk_i;

   bp_stream_lite_arbiter #(
      .bp_params_p   (e_bp_default_cfg),
      .num_masters_p (2),
      .data_width_p  (64),
      .max_beats_p   (8),
      .payload_mask_p(PM)
   ) dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .mem_header_i(mem_header_i),
      .mem_data_i  (mem_data_i),
      .mem_v_i     (v_in),
      .mem_lock_i  (lock_in),
      .mem_ready_o (ready_o),
      .mem_header_o(hdr_o),
      .mem_data_o  (data_o),
      .mem_v_o     (v_o),
      .mem_lock_o  (lock_o),
      .mem_ready_i (ready_in),
      .grant_id_o  (gid)
   );

   function automatic bp_bedrock_mem_msg_header_s mk(bp_bedrock_mem_type_e t,
                                                     bp_bedrock_msg_size_e s);
      bp_bedrock_mem_msg_header_s h;
      h          = '0;
      h.msg_type = t;
      h.size     = s;
      h.addr     = 40'h80_0000_0040;
      return h;
   endfunction

   // Reset held from time 0 while both masters request: every output is 0.
   task automatic test_reset();
      v_in     = 2'b11;
      lock_in  = 2'b11;
      ready_in = 1'b1;
      hdr[0]   = mk(e_bedrock_mem_wr, e_bedrock_msg_size_64);
      hdr[1]   = mk(e_bedrock_mem_wr, e_bedrock_msg_size_64);
      dat[0]   = 64'h1111;
      dat[1]   = 64'h2222;
      #3;
      n_cmp++; if (ready_o !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", ready_o); end
      n_cmp++; if (v_o !== 1'b0) begin n_bad++; $display("FAIL reset_v: got %b want 0", v_o); end
      n_cmp++; if (gid !== 1'b0) begin n_bad++; $display("FAIL reset_gid: got %0d want 0", gid); end
      n_cmp++; if (hdr_o !== '0) begin n_bad++; $display("FAIL reset_hdr: got %h want 0", hdr_o); end
      n_cmp++; if (data_o !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data_o); end
      n_cmp++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL reset_lock: got %b want 0", lock_o); end
      @(negedge clk_i);
      reset_n_i = 1'b1;
      v_in      = 2'b00;
      lock_in   = 2'b00;
   endtask

   // Both masters stream single-beat reads: grants alternate with no bubble.
   task automatic test_round_robin();
      logic [0:0] e_id;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         v_in     = 2'b11;
         lock_in  = 2'b00;
         ready_in = 1'b1;
         hdr[0]   = mk(e_bedrock_mem_rd, e_bedrock_msg_size_8);
         hdr[1]   = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8);
         dat[0]   = 64'hA000 + 64'(c);
         dat[1]   = 64'hB000 + 64'(c);
         e_id     = 1'(c % 2);
         #1;
         n_cmp++; if (gid !== e_id) begin n_bad++; $display("FAIL rr_gid c%0d: got %0d want %0d", c, gid, e_id); end
         n_cmp++; if (ready_o !== (e_id ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_ready c%0d: got %b want %b", c, ready_o, e_id ? 2'b10 : 2'b01); end
         n_cmp++; if (data_o !== (e_id ? 64'hB000 + 64'(c) : 64'hA000 + 64'(c))) begin n_bad++; $display("FAIL rr_data c%0d: got %h", c, data_o); end
         n_cmp++; if (v_o !== 1'b1) begin n_bad++; $display("FAIL rr_v c%0d: got %b want 1", c, v_o); end
         n_cmp++; if (hdr_o !== hdr[e_id]) begin n_bad++; $display("FAIL rr_hdr c%0d: got %h want %h", c, hdr_o, hdr[e_id]); end
      end
      @(negedge clk_i);
      v_in = 2'b00;
      #1;
      n_cmp++; if (v_o !== 1'b0) begin n_bad++; $display("FAIL rr_idle_v: got %b want 0", v_o); end
   endtask

   // M1 sends a 64B write (8 beats); M0 waits until the 8th handshake.
   task automatic test_multi_beat();
      @(negedge clk_i);
      v_in     = 2'b10;
      ready_in = 1'b1;
      hdr[1]   = mk(e_bedrock_mem_wr, e_bedrock_msg_size_64);
      dat[1]   = 64'hC000;
      hdr[0]   = mk(e_bedrock_mem_rd, e_bedrock_msg_size_8);
      dat[0]   = 64'hD000;
      #1;
      n_cmp++; if (gid !== 1'b1) begin n_bad++; $display("FAIL mb_gid b0: got %0d want 1", gid); end
      n_cmp++; if (ready_o !== 2'b10) begin n_bad++; $display("FAIL mb_ready b0: got %b want 10", ready_o); end
      for (int b = 1; b < 8; b++) begin
         @(negedge clk_i);
         v_in   = 2'b11;
         dat[1] = 64'hC000 + 64'(b);
         // Header on later beats must not restart the beat count.
         hdr[1] = mk(e_bedrock_mem_rd, e_bedrock_msg_size_8);
         #1;
         n_cmp++; if (gid !== 1'b1) begin n_bad++; $display("FAIL mb_gid b%0d: got %0d want 1", b, gid); end
         n_cmp++; if (ready_o !== 2'b10) begin n_bad++; $display("FAIL mb_ready b%0d: got %b want 10", b, ready_o); end
         n_cmp++; if (data_o !== 64'hC000 + 64'(b)) begin n_bad++; $display("FAIL mb_data b%0d: got %h want %h", b, data_o, 64'hC000 + 64'(b)); end
      end
      @(negedge clk_i);
      v_in = 2'b01;
      #1;
      n_cmp++; if (gid !== 1'b0) begin n_bad++; $display("FAIL mb_after_gid: got %0d want 0", gid); end
      n_cmp++; if (ready_o !== 2'b01) begin n_bad++; $display("FAIL mb_after_ready: got %b want 01", ready_o); end
      n_cmp++; if (data_o !== 64'hD000) begin n_bad++; $display("FAIL mb_after_data: got %h want d000", data_o); end
      @(negedge clk_i);
      v_in = 2'b00;
   endtask

   // 32B write from M0 (4 beats) with downstream ready toggling.
   task automatic test_stall();
      logic       pat  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0] ecnt [7] = '{3'd0, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1};
      int b;
      int n_hs;
      b    = 0;
      n_hs = 0;
      hdr[0]  = mk(e_bedrock_mem_wr, e_bedrock_msg_size_32);
      lock_in = 2'b00;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_i);
         v_in     = 2'b01;
         dat[0]   = 64'hE000 + 64'(b);
         ready_in = pat[i];
         #1;
         n_cmp++; if (gid !== 1'b0) begin n_bad++; $display("FAIL st_gid i%0d: got %0d want 0", i, gid); end
         n_cmp++; if (ready_o !== {1'b0, pat[i]}) begin n_bad++; $display("FAIL st_ready i%0d: got %b want %b", i, ready_o, {1'b0, pat[i]}); end
         n_cmp++; if (data_o !== 64'hE000 + 64'(b)) begin n_bad++; $display("FAIL st_data i%0d: got %h want %h", i, data_o, 64'hE000 + 64'(b)); end
         n_cmp++; if (dut.cnt_r !== ecnt[i]) begin n_bad++; $display("FAIL st_cnt i%0d: got %0d want %0d", i, dut.cnt_r, ecnt[i]); end
         if (v_o && ready_o[0] && ready_in) n_hs++;
         if (pat[i]) b++;
      end
      n_cmp++; if (n_hs !== 4) begin n_bad++; $display("FAIL st_handshakes: got %0d want 4", n_hs); end
      @(negedge clk_i);
      v_in     = 2'b10;
      ready_in = 1'b1;
      hdr[1]   = mk(e_bedrock_mem_rd, e_bedrock_msg_size_8);
      #1;
      n_cmp++; if (gid !== 1'b1) begin n_bad++; $display("FAIL st_after_gid: got %0d want 1", gid); end
      @(negedge clk_i);
      v_in = 2'b00;
   endtask

   // M0: locked single beat, locked 2-beat message, unlocked single beat;
   // M1 requests throughout and is served only afterwards.
   task automatic test_lock();
      @(negedge clk_i);
      v_in     = 2'b01;
      ready_in = 1'b1;
      lock_in  = 2'b01;
      hdr[0]   = mk(e_bedrock_mem_rd, e_bedrock_msg_size_8);
      dat[0]   = 64'hF000;
      #1;
      n_cmp++; if (gid !== 1'b0) begin n_bad++; $display("FAIL lk_gid c0: got %0d want 0", gid); end
      n_cmp++; if (lock_o !== 1'b1) begin n_bad++; $display("FAIL lk_lock c0: got %b want 1", lock_o); end
      @(negedge clk_i);
      v_in   = 2'b11;
      hdr[0] = mk(e_bedrock_mem_wr, e_bedrock_msg_size_16);
      dat[0] = 64'hF001;
      hdr[1] = mk(e_bedrock_mem_rd, e_bedrock_msg_size_8);
      dat[1] = 64'hF100;
      #1;
      n_cmp++; if (ready_o !== 2'b01) begin n_bad++; $display("FAIL lk_ready c1: got %b want 01", ready_o); end
      n_cmp++; if (data_o !== 64'hF001) begin n_bad++; $display("FAIL lk_data c1: got %h want f001", data_o); end
      @(negedge clk_i);
      dat[0] = 64'hF002;
      #1;
      n_cmp++; if (ready_o !== 2'b01) begin n_bad++; $display("FAIL lk_ready c2: got %b want 01", ready_o); end
      n_cmp++; if (data_o !== 64'hF002) begin n_bad++; $display("FAIL lk_data c2: got %h want f002", data_o); end
      @(negedge clk_i);
      hdr[0]  = mk(e_bedrock_mem_rd, e_bedrock_msg_size_8);
      dat[0]  = 64'hF003;
      lock_in = 2'b00;
      #1;
      n_cmp++; if (ready_o !== 2'b01) begin n_bad++; $display("FAIL lk_ready c3: got %b want 01", ready_o); end
      n_cmp++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL lk_lock c3: got %b want 0", lock_o); end
      @(negedge clk_i);
      #1;
      n_cmp++; if (gid !== 1'b1) begin n_bad++; $display("FAIL lk_gid c4: got %0d want 1", gid); end
      n_cmp++; if (ready_o !== 2'b10) begin n_bad++; $display("FAIL lk_ready c4: got %b want 10", ready_o); end
      n_cmp++; if (data_o !== 64'hF100) begin n_bad++; $display("FAIL lk_data c4: got %h want f100", data_o); end
      @(negedge clk_i);
      v_in = 2'b00;
   endtask

   // Reset pulsed at beat 3 of an 8-beat message from M1.
   task automatic test_reset_mid_message();
      @(negedge clk_i);
      v_in     = 2'b10;
      ready_in = 1'b1;
      hdr[1]   = mk(e_bedrock_mem_wr, e_bedrock_msg_size_64);
      dat[1]   = 64'h9000;
      hdr[0]   = mk(e_bedrock_mem_rd, e_bedrock_msg_size_8);
      dat[0]   = 64'h8000;
      for (int b = 1; b < 4; b++) begin
         @(negedge clk_i);
         v_in   = 2'b11;
         dat[1] = 64'h9000 + 64'(b);
      end
      #1;
      n_cmp++; if (gid !== 1'b1) begin n_bad++; $display("FAIL rm_gid b3: got %0d want 1", gid); end
      reset_n_i = 1'b0;
      #1;
      n_cmp++; if (ready_o !== 2'b00) begin n_bad++; $display("FAIL rm_ready: got %b want 00", ready_o); end
      n_cmp++; if (v_o !== 1'b0) begin n_bad++; $display("FAIL rm_v: got %b want 0", v_o); end
      n_cmp++; if (data_o !== 64'h0) begin n_bad++; $display("FAIL rm_data: got %h want 0", data_o); end
      @(negedge clk_i);
      reset_n_i = 1'b1;
      hdr[1]    = mk(e_bedrock_mem_rd, e_bedrock_msg_size_8);
      dat[0]    = 64'h8100;
      dat[1]    = 64'h8200;
      #1;
      n_cmp++; if (dut.rr_ptr_r !== 1'b0) begin n_bad++; $display("FAIL rm_rr_ptr: got %0d want 0", dut.rr_ptr_r); end
      n_cmp++; if (gid !== 1'b0) begin n_bad++; $display("FAIL rm_fresh_gid: got %0d want 0", gid); end
      n_cmp++; if (data_o !== 64'h8100) begin n_bad++; $display("FAIL rm_fresh_data: got %h want 8100", data_o); end
      @(negedge clk_i);
      #1;
      n_cmp++; if (gid !== 1'b1) begin n_bad++; $display("FAIL rm_next_gid: got %0d want 1", gid); end
      @(negedge clk_i);
      v_in = 2'b00;
   endtask

   // 64B read (type without data) and 1B write are both single-beat.
   task automatic test_non_payload();
      @(negedge clk_i);
      v_in     = 2'b11;
      ready_in = 1'b1;
      hdr[0]   = mk(e_bedrock_mem_rd, e_bedrock_msg_size_64);
      dat[0]   = 64'h7000;
      hdr[1]   = mk(e_bedrock_mem_rd, e_bedrock_msg_size_8);
      dat[1]   = 64'h7100;
      #1;
      n_cmp++; if (gid !== 1'b0) begin n_bad++; $display("FAIL np_gid c0: got %0d want 0", gid); end
      @(negedge clk_i);
      #1;
      n_cmp++; if (gid !== 1'b1) begin n_bad++; $display("FAIL np_gid c1: got %0d want 1", gid); end
      n_cmp++; if (data_o !== 64'h7100) begin n_bad++; $display("FAIL np_data c1: got %h want 7100", data_o); end
      @(negedge clk_i);
      hdr[0] = mk(e_bedrock_mem_wr, e_bedrock_msg_size_1);
      dat[0] = 64'h7200;
      #1;
      n_cmp++; if (gid !== 1'b0) begin n_bad++; $display("FAIL np_gid c2: got %0d want 0", gid); end
      @(negedge clk_i);
      #1;
      n_cmp++; if (gid !== 1'b1) begin n_bad++; $display("FAIL np_gid c3: got %0d want 1", gid); end
      @(negedge clk_i);
      v_in = 2'b00;
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      reset_n_i = 1'b0;
      v_in      = 2'b00;
      lock_in   = 2'b00;
      ready_in  = 1'b0;
      hdr[0]    = '0;
      hdr[1]    = '0;
      dat[0]    = '0;
      dat[1]    = '0;
      test_reset();
      test_round_robin();
      test_multi_beat();
      test_stall();
      test_lock();
      test_reset_mid_message();
      test_non_payload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
